// File: rtl/sync_pkg.sv
// Shared types and constants for the sync_filter_edge synchroniser slice.
package sync_pkg;

  localparam int SYNC_MIN_FLOPS   = 2;
  localparam int SYNC_MAX_FLOPS   = 4;
  localparam int GLITCH_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

  function automatic int filt_cnt_w(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchroniser chain, stability filter, edge pulses and, when
// SYNC_FILTER_GLITCH_CNT_EN is defined, a saturating glitch counter.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   NUM_FLOPS     = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter int   GLITCH_CNT_W  = GLITCH_CNT_W_DEF,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    async_i,
  input  logic                    bypass_i,
  input  logic                    glitch_clr_i,
  output logic                    sync_o,
  output logic                    rise_o,
  output logic                    fall_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  localparam int              CNT_W    = filt_cnt_w(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [NUM_FLOPS-1:0] chain_q;
  logic                 s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sync_q, sync_d;
  logic                 rise_q, fall_q;
  edge_e                edge_d;
  logic                 glitch_evt;

  // NOTE: the synchroniser chain is reset too, so no stale level can leak out after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {NUM_FLOPS{RST_VAL}};
    else        chain_q <= {chain_q[NUM_FLOPS-2:0], async_i};
  end

  assign s = chain_q[NUM_FLOPS-1];

  // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    cnt_d      = '0;
    sync_d     = sync_q;
    edge_d     = EDGE_NONE;
    glitch_evt = 1'b0;
    if (s != sync_q) begin
      if (bypass_i || cnt_q == CNT_LAST) begin
        sync_d = s;
        edge_d = s ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // A run that collapsed back to the accepted level was a rejected glitch.
      glitch_evt = !bypass_i && (cnt_q != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sync_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
      rise_q <= (edge_d == EDGE_RISE);
      fall_q <= (edge_d == EDGE_FALL);
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] gcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             gcnt_q <= '0;
    else if (glitch_clr_i)                  gcnt_q <= '0;
    else if (glitch_evt && gcnt_q != '1)    gcnt_q <= gcnt_q + GLITCH_CNT_W'(1);
  end

  assign glitch_cnt_o = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_evt ^ glitch_clr_i;
  assign glitch_cnt_o  = '0;
`endif

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel synchroniser + glitch filter + edge detector.
// Optional per-channel glitch counters are enabled by SYNC_FILTER_GLITCH_CNT_EN.
module sync_filter_edge
  import sync_pkg::*;
#(
  parameter int               NUM_FLOPS     = 2,
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] RST_VAL       = '0,
  parameter int               FILTER_CYCLES = 4,
  parameter int               GLITCH_CNT_W  = GLITCH_CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              async_in,
  input  logic [WIDTH-1:0]              filt_bypass,
  output logic [WIDTH-1:0]              sync_out,
  output logic [WIDTH-1:0]              rise_pulse,
  output logic [WIDTH-1:0]              fall_pulse,
  input  logic                          glitch_clr,
  output logic [WIDTH*GLITCH_CNT_W-1:0] glitch_cnt
);

  if (NUM_FLOPS < SYNC_MIN_FLOPS || NUM_FLOPS > SYNC_MAX_FLOPS) begin : g_bad_flops
    $error("sync_filter_edge: NUM_FLOPS must be in 2..4");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_filter_edge: WIDTH must be in 1..32");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("sync_filter_edge: FILTER_CYCLES must be in 1..255");
  end
  if (GLITCH_CNT_W < 1) begin : g_bad_gcnt
    $error("sync_filter_edge: GLITCH_CNT_W must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_ch #(
      .NUM_FLOPS    (NUM_FLOPS),
      .FILTER_CYCLES(FILTER_CYCLES),
      .GLITCH_CNT_W (GLITCH_CNT_W),
      .RST_VAL      (RST_VAL[i])
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .async_i     (async_in[i]),
      .bypass_i    (filt_bypass[i]),
      .glitch_clr_i(glitch_clr),
      .sync_o      (sync_out[i]),
      .rise_o      (rise_pulse[i]),
      .fall_o      (fall_pulse[i]),
      .glitch_cnt_o(glitch_cnt[i*GLITCH_CNT_W +: GLITCH_CNT_W])
    );
  end

endmodule
